// File: rtl/midi_mono_voice_pkg.sv
// Shared types, MIDI constants and the octave-9 frequency table for the mono voice.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// note_t / velocity_t   : 7-bit MIDI data values
// frequency_t           : nco phase increment, FREQUENCY_FRACTIONAL_BITS fraction bits
// MIDI_BASE_FREQ        : frequencies of notes 120..131 (C9..B9), rounded to the LSB
package midi_mono_voice_pkg;

    typedef logic [6:0] note_t;
    typedef logic [6:0] velocity_t;

    localparam int FREQUENCY_FRACTIONAL_BITS = 8;
    localparam int FREQUENCY_WIDTH           = 24;
    typedef logic [FREQUENCY_WIDTH-1:0] frequency_t;

    // Upper nibble of channel-voice status bytes
    localparam logic [3:0] MIDI_NOTE_OFF      = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON       = 4'h9;
    localparam logic [3:0] MIDI_CC            = 4'hB;
    localparam logic [3:0] MIDI_PROGRAM       = 4'hC;
    localparam logic [3:0] MIDI_CHAN_PRESSURE = 4'hD;
    localparam logic [6:0] MIDI_ALL_NOTES_OFF = 7'd123;

    typedef enum logic [2:0] {
        P_IDLE,
        P_D1,
        P_D2,
        P_SKIP1,
        P_SKIP2
    } parse_state_e;

    // Hz * 2^8 for MIDI notes 120..131; lower octaves are right shifts of these.
    localparam frequency_t MIDI_BASE_FREQ [12] = '{
        24'd2143237, 24'd2270680, 24'd2405702, 24'd2548752,
        24'd2700309, 24'd2860878, 24'd3030994, 24'd3211227,
        24'd3402176, 24'd3604480, 24'd3818814, 24'd4045892
    };

    // Note 127 lives in octave 10, so the shift never goes negative.
    function automatic frequency_t note_to_freq(input note_t n);
        logic [3:0] semi;
        logic [3:0] oct;
        semi = 4'(n % 7'd12);
        oct  = 4'(n / 7'd12);
        return MIDI_BASE_FREQ[semi] >> (4'd10 - oct);
    endfunction

endpackage

// File: rtl/midi_note_stack.sv
// Last-note-priority held-note stack; entry 0 is the top (most recent) note.
// Latency: every op takes effect on the clock edge it is presented; top/empty are registered.
// Backpressure: none; push/remove/clear are accepted every cycle (clear wins, then push).
//
// clock_i, reset_i (async, active-low)
// push_i   : remove note_i if held, then place it on top; bottom entry falls off when full
// remove_i : remove note_i if held and close the gap; absent note is a no-op
// clear_i  : empty the stack
// top_o    : note in entry 0 (meaningful only while !empty_o)
// empty_o  : no notes held
module midi_note_stack
    import midi_mono_voice_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic       remove_i,
    input  logic       clear_i,
    input  logic [6:0] note_i,
    output logic [6:0] top_o,
    output logic       empty_o
);

    note_t                   ent_q [STACK_DEPTH];
    note_t                   ent_d [STACK_DEPTH];
    logic [STACK_DEPTH-1:0]  vld_q;
    logic [STACK_DEPTH-1:0]  vld_d;
    logic [STACK_DEPTH-1:0]  match;
    // hit[i]: note_i is held somewhere in entries 0..i. Entries with hit set are
    // the ones that move when the matching entry is taken out.
    logic [STACK_DEPTH-1:0]  hit;

    always_comb begin
        match = '0;
        hit   = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            match[i] = vld_q[i] && (ent_q[i] == note_i);
        end
        hit[0] = match[0];
        for (int i = 1; i < STACK_DEPTH; i++) begin
            hit[i] = hit[i-1] | match[i];
        end
    end

    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        if (clear_i) begin
            vld_d = '0;
        end else if (push_i) begin
            // Shift down everything above the old copy (or everything if absent,
            // which pushes the bottom entry out).
            ent_d[0] = note_i;
            vld_d[0] = 1'b1;
            for (int i = 1; i < STACK_DEPTH; i++) begin
                if (!hit[i-1]) begin
                    ent_d[i] = ent_q[i-1];
                    vld_d[i] = vld_q[i-1];
                end
            end
        end else if (remove_i) begin
            // Pull up everything below the removed entry.
            for (int i = 0; i < STACK_DEPTH - 1; i++) begin
                if (hit[i]) begin
                    ent_d[i] = ent_q[i+1];
                    vld_d[i] = vld_q[i+1];
                end
            end
            if (hit[STACK_DEPTH-1]) begin
                vld_d[STACK_DEPTH-1] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            vld_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ent_q <= ent_d;
        end
    end

    assign top_o   = ent_q[0];
    assign empty_o = !vld_q[0];

endmodule

// File: rtl/midi_mono_voice.sv
// MIDI byte stream -> monophonic voice control (gate, note, velocity, retrig, nco increment).
// Latency: gate/note/velocity/retrig 1 clock after the final byte; freq 1 clock after note.
// Backpressure: none; one byte per cycle on rx_valid_i, every byte is consumed.
//
// clock_i, reset_i (async, active-low)   channel_i: MIDI channel accepted (0 = ch 1)
// rx_data_i/rx_valid_i: UART bytes       gate_o: notes held   note_o: top note (held at gate fall)
// velocity_o: last Note On velocity      retrig_o: top note changed while notes stay held
// freq_o: nco increment; only produced when MIDI_FREQ_LUT_EN is defined, otherwise 0
module midi_mono_voice
    import midi_mono_voice_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic [3:0]                 channel_i,
    input  logic [7:0]                 rx_data_i,
    input  logic                       rx_valid_i,
    output logic                       gate_o,
    output logic [6:0]                 note_o,
    output logic [6:0]                 velocity_o,
    output logic                       retrig_o,
    output logic [FREQUENCY_WIDTH-1:0] freq_o
);

    parse_state_e state_q;
    logic [3:0]   status_q;      // running status (upper nibble) of the accepted message
    note_t        data1_q;
    logic         skip2_q;       // skipped message carries two data bytes
    velocity_t    velocity_q;
    note_t        hold_q;        // last top note seen while the stack was non-empty
    logic         held_q;        // stack was non-empty last cycle

    logic [3:0] hi;
    logic       is_data, is_system, accept, short_msg;
    logic       exec, push, remove, clear;
    note_t      top;
    logic       empty;

    assign hi        = rx_data_i[7:4];
    assign is_data   = !rx_data_i[7];
    assign is_system = (hi == 4'hF);
    assign accept    = ((hi == MIDI_NOTE_OFF) || (hi == MIDI_NOTE_ON) || (hi == MIDI_CC))
                       && (rx_data_i[3:0] == channel_i);
    assign short_msg = (hi == MIDI_PROGRAM) || (hi == MIDI_CHAN_PRESSURE);

    // The second data byte is executed in its own cycle so the stack lands one clock later.
    assign exec   = rx_valid_i && is_data && (state_q == P_D2);
    assign push   = exec && (status_q == MIDI_NOTE_ON) && (rx_data_i[6:0] != 7'd0);
    assign remove = exec && ((status_q == MIDI_NOTE_OFF)
                             || ((status_q == MIDI_NOTE_ON) && (rx_data_i[6:0] == 7'd0)));
    assign clear  = exec && (status_q == MIDI_CC) && (data1_q == MIDI_ALL_NOTES_OFF);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= P_IDLE;
            status_q   <= '0;
            data1_q    <= '0;
            skip2_q    <= 1'b0;
            velocity_q <= '0;
        end else if (rx_valid_i) begin
            if (is_system) begin
                // Realtime (F8-FF) passes through untouched; F0-F7 kill running status.
                if (!rx_data_i[3]) begin
                    state_q <= P_IDLE;
                end
            end else if (!is_data) begin
                if (accept) begin
                    status_q <= hi;
                    state_q  <= P_D1;
                end else begin
                    skip2_q <= !short_msg;
                    state_q <= short_msg ? P_SKIP1 : P_SKIP2;
                end
            end else begin
                case (state_q)
                    P_D1: begin
                        data1_q <= rx_data_i[6:0];
                        state_q <= P_D2;
                    end
                    P_D2: begin
                        state_q <= P_D1;
                        if (push) begin
                            velocity_q <= rx_data_i[6:0];
                        end
                    end
                    P_SKIP1: state_q <= skip2_q ? P_SKIP2 : P_SKIP1;
                    P_SKIP2: state_q <= P_SKIP1;
                    default: state_q <= P_IDLE;
                endcase
            end
        end
    end

    midi_note_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .push_i   (push),
        .remove_i (remove),
        .clear_i  (clear),
        .note_i   (data1_q),
        .top_o    (top),
        .empty_o  (empty)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            hold_q <= '0;
            held_q <= 1'b0;
        end else begin
            held_q <= !empty;
            if (!empty) begin
                hold_q <= top;
            end
        end
    end

    assign gate_o     = !empty;
    assign note_o     = empty ? hold_q : top;
    assign velocity_o = velocity_q;
    // A fresh gate is not a retrigger; only a top change under a held gate is.
    assign retrig_o   = !empty && held_q && (top != hold_q);

`ifdef MIDI_FREQ_LUT_EN
    frequency_t freq_q;
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            freq_q <= '0;
        end else if (gate_o) begin
            freq_q <= note_to_freq(note_o);
        end
    end
    assign freq_o = freq_q;
`else
    assign freq_o = '0;
`endif

endmodule
